// File: rtl/serial_frame_receiver_pkg.sv
// Shared state encoding and line levels for the serial frame receiver.
package serial_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/serial_frame_receiver_bit_counter.sv
// Data-bit position counter: synchronous clear/enable, flags the last data bit.
module rx_bit_counter #(
  parameter int unsigned DATA_W = 8,
  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(DATA_W - 1));
endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start | DATA_W bits LSB first | [parity] | stop.
// Optional parity check enabled by defining PARITY_CHECK_EN.
module serial_frame_receiver
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  output logic              frameErr,
  output logic              busy
);
  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              tc;
  logic              parity_ok;

  rx_bit_counter #(.DATA_W(DATA_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != DATA),
    .en    (state == DATA),
    .cnt   (cnt),
    .tc    (tc)
  );

`ifdef PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (state == PARITY) begin
      par_bit <= sIn;
    end
  end

  assign parity_ok = (((^shreg) ^ PARITY_ODD[0]) == par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  // Stop state always returns to IDLE, so a bad stop bit cannot double as a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      frameErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      frameErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (sIn == START_LEVEL) begin
            state <= DATA;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          shreg[cnt] <= sIn;
          if (tc) begin
`ifdef PARITY_CHECK_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
        PARITY: begin
          state <= STOP;
        end
        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (sIn == STOP_LEVEL && parity_ok) begin
            dataOut   <= shreg;
            dataValid <= 1'b1;
          end else begin
            frameErr <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
